mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 6 +
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Bus widths shared between the core and the memory arbiter.
package mem_arbiter_pkg;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;
    localparam int BSEL_W = 2;
endpackage

// File: rtl/mem_arbiter.sv
// Purpose: merges the core's instruction and data ports onto one backend port, round-robin on ties.
// Latency: a request seen in IDLE is granted next cycle; acks and read data pass through combinationally.
// Backpressure: a grant is held until q_m_ack; the other requester simply stays pending until re-arbitration.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W:1]   instr_m_addr,
    output logic [DATA_W-1:0] instr_m_data_in,
    input  logic              instr_m_access,
    output logic              instr_m_ack,

    input  logic [ADDR_W:1]   data_m_addr,
    output logic [DATA_W-1:0] data_m_data_in,
    input  logic [DATA_W-1:0] data_m_data_out,
    input  logic              data_m_access,
    output logic              data_m_ack,
    input  logic              data_m_wr_en,
    input  logic [BSEL_W-1:0] data_m_bytesel,
    input  logic              d_io,

    output logic [ADDR_W:1]   q_m_addr,
    input  logic [DATA_W-1:0] q_m_data_in,
    output logic [DATA_W-1:0] q_m_data_out,
    output logic              q_m_access,
    input  logic              q_m_ack,
    output logic              q_m_wr_en,
    output logic [BSEL_W-1:0] q_m_bytesel,
    output logic              q_m_io
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_DATA  = 2'd1,
        GRANT_INSTR = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_was_data_q, last_was_data_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            last_was_data_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_was_data_q <= last_was_data_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        last_was_data_d = last_was_data_q;
        case (state_q)
            IDLE: begin
                // On a tie the port that was not served last wins.
                if (data_m_access && (!instr_m_access || !last_was_data_q)) begin
                    state_d = GRANT_DATA;
                end else if (instr_m_access) begin
                    state_d = GRANT_INSTR;
                end
            end
            GRANT_DATA: begin
                if (q_m_ack) begin
                    state_d         = IDLE;
                    last_was_data_d = 1'b1;
                end
            end
            GRANT_INSTR: begin
                if (q_m_ack) begin
                    state_d         = IDLE;
                    last_was_data_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        q_m_access   = 1'b0;
        q_m_addr     = '0;
        q_m_data_out = '0;
        q_m_wr_en    = 1'b0;
        q_m_bytesel  = '0;
        q_m_io       = 1'b0;
        case (state_q)
            GRANT_DATA: begin
                q_m_access   = 1'b1;
                q_m_addr     = data_m_addr;
                q_m_data_out = data_m_data_out;
                q_m_wr_en    = data_m_wr_en;
                q_m_bytesel  = data_m_bytesel;
                q_m_io       = d_io;
            end
            GRANT_INSTR: begin
                q_m_access  = 1'b1;
                q_m_addr    = instr_m_addr;
                q_m_bytesel = {BSEL_W{1'b1}};
            end
            default: begin
            end
        endcase
    end

    assign instr_m_data_in = q_m_data_in;
    assign data_m_data_in  = q_m_data_in;
    assign data_m_ack      = q_m_ack && (state_q == GRANT_DATA);
    assign instr_m_ack     = q_m_ack && (state_q == GRANT_INSTR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal spot checks.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W:1]   instr_m_addr;
    logic [DATA_W-1:0] instr_m_data_in;
    logic              instr_m_access;
    logic              instr_m_ack;
    logic [ADDR_W:1]   data_m_addr;
    logic [DATA_W-1:0] data_m_data_in;
    logic [DATA_W-1:0] data_m_data_out;
    logic              data_m_access;
    logic              data_m_ack;
    logic              data_m_wr_en;
    logic [BSEL_W-1:0] data_m_bytesel;
    logic              d_io;
    logic [ADDR_W:1]   q_m_addr;
    logic [DATA_W-1:0] q_m_data_in;
    logic [DATA_W-1:0] q_m_data_out;
    logic              q_m_access;
    logic              q_m_ack;
    logic              q_m_wr_en;
    logic [BSEL_W-1:0] q_m_bytesel;
    logic              q_m_io;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .instr_m_addr    (instr_m_addr),
        .instr_m_data_in (instr_m_data_in),
        .instr_m_access  (instr_m_access),
        .instr_m_ack     (instr_m_ack),
        .data_m_addr     (data_m_addr),
        .data_m_data_in  (data_m_data_in),
        .data_m_data_out (data_m_data_out),
        .data_m_access   (data_m_access),
        .data_m_ack      (data_m_ack),
        .data_m_wr_en    (data_m_wr_en),
        .data_m_bytesel  (data_m_bytesel),
        .d_io            (d_io),
        .q_m_addr        (q_m_addr),
        .q_m_data_in     (q_m_data_in),
        .q_m_data_out    (q_m_data_out),
        .q_m_access      (q_m_access),
        .q_m_ack         (q_m_ack),
        .q_m_wr_en       (q_m_wr_en),
        .q_m_bytesel     (q_m_bytesel),
        .q_m_io          (q_m_io)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: who currently owns the backend (0 nobody, 1 data, 2 instr) and who was served last.
    int m_owner;
    bit m_last_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner     <= 0;
            m_last_data <= 1'b0;
        end else if (m_owner == 0) begin
            if (data_m_access && instr_m_access) m_owner <= m_last_data ? 2 : 1;
            else if (data_m_access)              m_owner <= 1;
            else if (instr_m_access)             m_owner <= 2;
        end else if (q_m_ack) begin
            m_last_data <= (m_owner == 1);
            m_owner     <= 0;
        end
    end

    always @(negedge clk) begin : compare
        logic [ADDR_W:1]   e_addr;
        logic [DATA_W-1:0] e_dout;
        logic [BSEL_W-1:0] e_bsel;
        logic              e_wr, e_io;
        e_addr = (m_owner == 1) ? data_m_addr : (m_owner == 2) ? instr_m_addr : '0;
        e_dout = (m_owner == 1) ? data_m_data_out : '0;
        e_bsel = (m_owner == 1) ? data_m_bytesel : (m_owner == 2) ? 2'b11 : 2'b00;
        e_wr   = (m_owner == 1) ? data_m_wr_en : 1'b0;
        e_io   = (m_owner == 1) ? d_io : 1'b0;
        chk("cyc_access",  32'(q_m_access),      32'(m_owner != 0));
        chk("cyc_addr",    32'(q_m_addr),        32'(e_addr));
        chk("cyc_dout",    32'(q_m_data_out),    32'(e_dout));
        chk("cyc_bsel",    32'(q_m_bytesel),     32'(e_bsel));
        chk("cyc_wr_en",   32'(q_m_wr_en),       32'(e_wr));
        chk("cyc_io",      32'(q_m_io),          32'(e_io));
        chk("cyc_d_ack",   32'(data_m_ack),      32'(q_m_ack && m_owner == 1));
        chk("cyc_i_ack",   32'(instr_m_ack),     32'(q_m_ack && m_owner == 2));
        chk("cyc_d_rdata", 32'(data_m_data_in),  32'(q_m_data_in));
        chk("cyc_i_rdata", 32'(instr_m_data_in), 32'(q_m_data_in));
    end

    // Grant monitor: order of granted addresses and idle cycles preceding each grant.
    bit              mon_en = 1'b0;
    logic            prev_acc;
    int              idle_run;
    logic [ADDR_W:1] grant_addr_q[$];
    int              grant_gap_q[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (q_m_access && !prev_acc) begin
                grant_addr_q.push_back(q_m_addr);
                grant_gap_q.push_back(idle_run);
                idle_run = 0;
            end else if (!q_m_access) begin
                idle_run++;
            end
            prev_acc = q_m_access;
        end
    end

    // Backend responder: acks after be_wait extra cycles of a grant when enabled.
    bit be_auto = 1'b0;
    int be_wait = 0;
    int be_cnt  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (be_auto) begin
            if (q_m_access) begin
                q_m_ack = (be_cnt == be_wait);
                be_cnt  = q_m_ack ? 0 : be_cnt + 1;
            end else begin
                q_m_ack = 1'b0;
                be_cnt  = 0;
            end
        end
        #1;
    endtask

    task automatic wait_ack(input bit is_data, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (is_data ? data_m_ack : instr_m_ack) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL ack_timeout is_data=%0d actual=no_ack expected=ack within %0d cycles", is_data, budget);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        q_m_ack = 1'b0;
        be_cnt  = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        reset           = 1'b1;
        instr_m_addr    = '0;
        instr_m_access  = 1'b0;
        data_m_addr     = '0;
        data_m_data_out = '0;
        data_m_access   = 1'b0;
        data_m_wr_en    = 1'b0;
        data_m_bytesel  = 2'b11;
        d_io            = 1'b0;
        q_m_data_in     = '0;
        q_m_ack         = 1'b0;

        // Data read with one wait cycle.
        do_reset();
        chk("reset_access", 32'(q_m_access), 32'd0);
        be_auto = 1'b1; be_wait = 1;
        q_m_data_in   = 16'hBEEF;
        data_m_addr   = 19'h00010;
        data_m_access = 1'b1;
        chk("lat_cycle_n", 32'(q_m_access), 32'd0);
        tick();
        chk("lat_cycle_n1", 32'(q_m_access), 32'd1);
        chk("rd_addr", 32'(q_m_addr), 32'h00010);
        wait_ack(1'b1, 10, n);
        chk("rd_ack_wait", 32'(n), 32'd1);
        chk("rd_rdata", 32'(data_m_data_in), 32'hBEEF);
        chk("rd_no_iack", 32'(instr_m_ack), 32'd0);
        data_m_access = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(data_m_ack);
        end
        chk("rd_single_pulse", 32'(pulses), 32'd0);

        // Instruction fetch against a zero-wait backend; data-side fields must not leak.
        be_wait = 0;
        q_m_data_in     = 16'hA5C3;
        data_m_wr_en    = 1'b1;
        d_io            = 1'b1;
        data_m_data_out = 16'hFFFF;
        instr_m_addr    = 19'h7FFF8;
        instr_m_access  = 1'b1;
        wait_ack(1'b0, 10, n);
        chk("if_ack_n1", 32'(n), 32'd1);
        chk("if_addr", 32'(q_m_addr), 32'h7FFF8);
        chk("if_wr_en", 32'(q_m_wr_en), 32'd0);
        chk("if_bsel", 32'(q_m_bytesel), 32'h3);
        chk("if_io", 32'(q_m_io), 32'd0);
        chk("if_dout", 32'(q_m_data_out), 32'd0);
        chk("if_rdata", 32'(instr_m_data_in), 32'hA5C3);
        instr_m_access = 1'b0;
        tick();

        // Data write to I/O space.
        data_m_addr     = 19'h12345;
        data_m_data_out = 16'h1234;
        data_m_bytesel  = 2'b10;
        data_m_access   = 1'b1;
        wait_ack(1'b1, 10, n);
        chk("wr_dout", 32'(q_m_data_out), 32'h1234);
        chk("wr_bsel", 32'(q_m_bytesel), 32'h2);
        chk("wr_io", 32'(q_m_io), 32'd1);
        chk("wr_en", 32'(q_m_wr_en), 32'd1);
        chk("wr_addr", 32'(q_m_addr), 32'h12345);
        data_m_access  = 1'b0;
        data_m_wr_en   = 1'b0;
        d_io           = 1'b0;
        data_m_bytesel = 2'b11;
        tick();

        // Both requesting from reset, backend acks on the third grant cycle.
        reset   = 1'b1;
        be_wait = 2;
        be_cnt  = 0;
        data_m_addr    = 19'h0000D;
        instr_m_addr   = 19'h0000A;
        data_m_access  = 1'b1;
        instr_m_access = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        prev_acc = 1'b0;
        idle_run = 0;
        grant_addr_q.delete();
        grant_gap_q.delete();
        mon_en = 1'b1;
        tick();
        chk("first_edge_grant", 32'(q_m_access), 32'd1);
        chk("first_tie_data", 32'(q_m_addr), 32'h0000D);
        for (int i = 0; i < 40 && grant_addr_q.size() < 4; i++) tick();
        chk("rr_grant_count", 32'(grant_addr_q.size()), 32'd4);
        if (grant_addr_q.size() >= 4) begin
            chk("rr_order0", 32'(grant_addr_q[0]), 32'h0000D);
            chk("rr_order1", 32'(grant_addr_q[1]), 32'h0000A);
            chk("rr_order2", 32'(grant_addr_q[2]), 32'h0000D);
            chk("rr_order3", 32'(grant_addr_q[3]), 32'h0000A);
            for (int i = 1; i < 4; i++) chk("rr_idle_gap", 32'(grant_gap_q[i]), 32'd1);
        end
        mon_en         = 1'b0;
        data_m_access  = 1'b0;
        instr_m_access = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Data requester drops early: grant held, pending instr served next.
        be_auto = 1'b0;
        q_m_ack = 1'b0;
        data_m_access = 1'b1;
        tick();
        instr_m_access = 1'b1;
        data_m_access  = 1'b0;
        tick();
        tick();
        chk("held_access", 32'(q_m_access), 32'd1);
        chk("held_addr", 32'(q_m_addr), 32'h0000D);
        q_m_ack = 1'b1;
        #1;
        chk("held_d_ack", 32'(data_m_ack), 32'd1);
        chk("held_no_iack", 32'(instr_m_ack), 32'd0);
        tick();
        q_m_ack = 1'b0;
        chk("rearb_idle", 32'(q_m_access), 32'd0);
        tick();
        chk("pending_access", 32'(q_m_access), 32'd1);
        chk("pending_addr", 32'(q_m_addr), 32'h0000A);
        be_cnt = 0; be_wait = 0; be_auto = 1'b1;
        wait_ack(1'b0, 10, n);
        instr_m_access = 1'b0;
        tick();

        // Reset while an instruction fetch is in flight.
        be_auto = 1'b0;
        q_m_ack = 1'b0;
        instr_m_access = 1'b1;
        tick();
        chk("pre_rst_access", 32'(q_m_access), 32'd1);
        #1;
        reset   = 1'b1;
        q_m_ack = 1'b1;
        #1;
        chk("rst_access_now", 32'(q_m_access), 32'd0);
        chk("rst_no_iack", 32'(instr_m_ack), 32'd0);
        chk("rst_no_dack", 32'(data_m_ack), 32'd0);
        instr_m_access = 1'b0;
        tick();
        reset   = 1'b0;
        q_m_ack = 1'b0;
        tick();
        chk("post_rst_idle", 32'(q_m_access), 32'd0);
        data_m_access = 1'b1;
        be_cnt = 0; be_wait = 0; be_auto = 1'b1;
        wait_ack(1'b1, 10, n);
        chk("post_rst_data_n1", 32'(n), 32'd1);
        data_m_access = 1'b0;
        tick();

        // Stray backend ack while idle.
        be_auto = 1'b0;
        q_m_ack = 1'b0;
        tick();
        q_m_ack = 1'b1;
        #1;
        chk("idle_ack_d", 32'(data_m_ack), 32'd0);
        chk("idle_ack_i", 32'(instr_m_ack), 32'd0);
        tick();
        q_m_ack = 1'b0;
        chk("idle_ack_stay", 32'(q_m_access), 32'd0);

        // Data served last, so the next tie goes to instr.
        data_m_access  = 1'b1;
        instr_m_access = 1'b1;
        tick();
        chk("tie_instr_access", 32'(q_m_access), 32'd1);
        chk("tie_instr_addr", 32'(q_m_addr), 32'h0000A);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
